// File: rtl/portal_ind_mux_pkg.sv
// -----------------------------------------------------------------------------
// portal_ind_pkg
// Shared constants and helpers for the multi-channel indication portal mux.
//   clog2          : ceiling log2, used to size FIFO pointers
//   MSG_SIZE_NONE  : messageSize answer for an unknown method
//   INTR_MASK_RST  : interrupt enable mask after reset (sliced to NCHAN)
//   RR_PTR_RST     : round-robin pointer value after reset
// -----------------------------------------------------------------------------
package portal_ind_pkg;

    localparam logic [15:0] MSG_SIZE_NONE = 16'd0;
    localparam logic [15:0] INTR_MASK_RST = 16'hFFFF;
    localparam int          RR_PTR_RST    = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/portal_ind_mux_if.sv
// -----------------------------------------------------------------------------
// portal_ind_mux_if
// Bundles the indication enqueue side, the host dequeue side, the interrupt
// controls and the messageSize query of portal_ind_mux.
//   master : user core / host side (drives enq, deq, mask and size query)
//   slave  : the portal mux itself
// -----------------------------------------------------------------------------
interface portal_ind_mux_if #(
    parameter int NCHAN = 4,
    parameter int W     = 32,
    parameter int CW    = 4
);
    logic [NCHAN-1:0]   enq_en;
    logic [NCHAN-1:0]   enq_rdy;
    logic [NCHAN*W-1:0] enq_data;
    logic [CW-1:0]      deq_sel;
    logic               deq_en;
    logic               deq_rdy;
    logic [W-1:0]       first;
    logic [NCHAN-1:0]   not_empty;
    logic               intr_mask_wr;
    logic [NCHAN-1:0]   intr_mask_data;
    logic               intr_status;
    logic [31:0]        intr_channel;
    logic [15:0]        msg_size_method;
    logic [15:0]        msg_size;

    modport master (
        output enq_en, enq_data, deq_sel, deq_en,
               intr_mask_wr, intr_mask_data, msg_size_method,
        input  enq_rdy, deq_rdy, first, not_empty,
               intr_status, intr_channel, msg_size
    );

    modport slave (
        input  enq_en, enq_data, deq_sel, deq_en,
               intr_mask_wr, intr_mask_data, msg_size_method,
        output enq_rdy, deq_rdy, first, not_empty,
               intr_status, intr_channel, msg_size
    );
endinterface

// File: rtl/portal_ind_mux_fifo.sv
// -----------------------------------------------------------------------------
// portal_ind_fifo
// Single-clock FIFO holding the indication words of one channel.
//   clk, rst  : clock, synchronous active-high reset (control state only)
//   enq_en    : write enq_data when there is room (or a pop frees a slot)
//   enq_rdy   : not full
//   deq_en    : pop head when non-empty
//   deq_rdy   : not empty
//   first     : head word, forced to 0 while empty
// -----------------------------------------------------------------------------
module portal_ind_fifo
    import portal_ind_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enq_en,
    output logic         enq_rdy,
    input  logic [W-1:0] enq_data,
    input  logic         deq_en,
    output logic         deq_rdy,
    output logic [W-1:0] first
);
    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_enq;
    logic          do_deq;

    assign full    = (count == (AW+1)'(DEPTH));
    assign enq_rdy = !full;
    assign deq_rdy = (count != '0);
    assign first   = deq_rdy ? mem[rd_ptr] : '0;

    // A full FIFO still accepts a write in the same cycle as a pop: the
    // slot being written is the one the head is leaving.
    assign do_deq = deq_en && deq_rdy;
    assign do_enq = enq_en && (!full || do_deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_enq && !do_deq) begin
                count <= count + 1'b1;
            end else if (!do_enq && do_deq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is not reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end
endmodule

// File: rtl/portal_ind_mux.sv
// -----------------------------------------------------------------------------
// portal_ind_mux
// Multi-channel indication output portal: NCHAN per-channel FIFOs, a selectable
// notEmpty/first/deq host view, a maskable registered interrupt reporting the
// interrupting channel number + 1, and a per-method messageSize lookup.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : portal_ind_mux_if.slave (enq_*, deq_*, first, not_empty,
//              intr_*, msg_size*)
// Build option: define PORTAL_IND_MUX_ROUND_ROBIN_EN to pick the interrupting
// channel round-robin (starting at the channel after the last one popped)
// instead of fixed lowest-index priority.
// -----------------------------------------------------------------------------
module portal_ind_mux
    import portal_ind_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic            CLK,
    input  logic            RST,
    portal_ind_mux_if.slave bus
);
    logic [NCHAN-1:0] enq_rdy_v;
    logic [NCHAN-1:0] ne_v;
    logic [NCHAN-1:0] fifo_deq;
    logic [W-1:0]     head [NCHAN];
    logic [NCHAN-1:0] mask;
    logic [NCHAN-1:0] pend;
    logic             intr_status_r;
    logic [31:0]      intr_channel_r;
    logic [31:0]      intr_next;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        portal_ind_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (CLK),
            .rst      (RST),
            .enq_en   (bus.enq_en[c]),
            .enq_rdy  (enq_rdy_v[c]),
            .enq_data (bus.enq_data[c*W +: W]),
            .deq_en   (fifo_deq[c]),
            .deq_rdy  (ne_v[c]),
            .first    (head[c])
        );
    end

    assign bus.enq_rdy   = enq_rdy_v;
    assign bus.not_empty = ne_v;

    // Selects outside 0..NCHAN-1 match no channel and so read as empty.
    always_comb begin
        fifo_deq    = '0;
        bus.deq_rdy = 1'b0;
        bus.first   = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (bus.deq_sel == CW'(c)) begin
                bus.deq_rdy = ne_v[c];
                bus.first   = head[c];
                fifo_deq[c] = bus.deq_en;
            end
        end
    end

    assign pend = ne_v & mask;

`ifdef PORTAL_IND_MUX_ROUND_ROBIN_EN
    logic [CW-1:0] rr_ptr;

    // Scan downward so the closest pending channel at or after start wins.
    function automatic logic [31:0] enc_rr(input logic [NCHAN-1:0] p,
                                           input int start);
        logic [31:0] enc;
        int          idx;
        enc = '0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            idx = (start + k) % NCHAN;
            if (p[idx]) begin
                enc = 32'(idx + 1);
            end
        end
        return enc;
    endfunction

    assign intr_next = enc_rr(pend, int'(rr_ptr));

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= CW'(RR_PTR_RST);
        end else if (bus.deq_en && bus.deq_rdy) begin
            rr_ptr <= (int'(bus.deq_sel) + 1 >= NCHAN) ? '0
                                                       : bus.deq_sel + CW'(1);
        end
    end
`else
    function automatic logic [31:0] enc_lowest(input logic [NCHAN-1:0] p);
        logic [31:0] enc;
        enc = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (p[i]) begin
                enc = 32'(i + 1);
            end
        end
        return enc;
    endfunction

    assign intr_next = enc_lowest(pend);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            mask           <= INTR_MASK_RST[NCHAN-1:0];
            intr_status_r  <= 1'b0;
            intr_channel_r <= '0;
        end else begin
            if (bus.intr_mask_wr) begin
                mask <= bus.intr_mask_data;
            end
            intr_status_r  <= |pend;
            intr_channel_r <= intr_next;
        end
    end

    assign bus.intr_status  = intr_status_r;
    assign bus.intr_channel = intr_channel_r;

    assign bus.msg_size = (int'(bus.msg_size_method) < NCHAN) ? 16'(W)
                                                              : MSG_SIZE_NONE;
endmodule

// File: tb/tb_portal_ind_mux.sv
// -----------------------------------------------------------------------------
// tb_portal_ind_mux
// Directed bench for portal_ind_mux (NCHAN=4, W=32, DEPTH=8, CW=4). Expected
// dequeue words are queued when a pop is issued; a negedge monitor pops and
// compares them against first whenever deq_en && deq_rdy.
// -----------------------------------------------------------------------------
module tb_portal_ind_mux;
    localparam int NCHAN = 4;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] exp_q [$];

    portal_ind_mux_if #(.NCHAN(NCHAN), .W(W), .CW(CW)) bus ();

    portal_ind_mux #(
        .NCHAN (NCHAN),
        .W     (W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted pop must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.deq_en && bus.deq_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%h required=none", bus.first);
            end else begin
                chk("deq_first", bus.first, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic enq_set(input int ch, input logic [31:0] d);
        bus.enq_en[ch]           = 1'b1;
        bus.enq_data[ch*W +: W]  = d;
    endtask

    task automatic enq_clr();
        bus.enq_en = '0;
    endtask

    task automatic deq_one(input int ch, input logic [31:0] e);
        bus.deq_sel = CW'(ch);
        bus.deq_en  = 1'b1;
        exp_q.push_back(e);
        cyc();
        bus.deq_en  = 1'b0;
    endtask

    task automatic mask_wr(input logic [NCHAN-1:0] m);
        bus.intr_mask_wr   = 1'b1;
        bus.intr_mask_data = m;
        cyc();
        bus.intr_mask_wr   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst                 = 1'b1;
        bus.enq_en          = '0;
        bus.enq_data        = '0;
        bus.deq_sel         = '0;
        bus.deq_en          = 1'b0;
        bus.intr_mask_wr    = 1'b0;
        bus.intr_mask_data  = '0;
        bus.msg_size_method = '0;

        // Reset state
        cyc();
        cyc();
        at_neg();
        chk("rst_enq_rdy", 32'(bus.enq_rdy), 32'hF);
        chk("rst_not_empty", 32'(bus.not_empty), 32'h0);
        chk("rst_deq_rdy", 32'(bus.deq_rdy), 32'h0);
        chk("rst_first", bus.first, 32'h0);
        chk("rst_intr_status", 32'(bus.intr_status), 32'h0);
        chk("rst_intr_channel", bus.intr_channel, 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        at_neg();
        chk("idle_enq_rdy", 32'(bus.enq_rdy), 32'hF);
        chk("idle_intr_status", 32'(bus.intr_status), 32'h0);

        // messageSize lookup
        bus.msg_size_method = 16'd2;
        at_neg();
        chk("msg_size_m2", 32'(bus.msg_size), 32'd32);
        bus.msg_size_method = 16'd7;
        at_neg();
        chk("msg_size_m7", 32'(bus.msg_size), 32'd0);

        // Channel 2 fill, overflow attempt, ordered drain
        cyc();
        for (int i = 1; i <= 8; i++) begin
            enq_set(2, 32'hA5A5_0000 + 32'(i));
            cyc();
        end
        enq_clr();
        at_neg();
        chk("ch2_full_enq_rdy", 32'(bus.enq_rdy), 32'hB);
        chk("ch2_not_empty", 32'(bus.not_empty), 32'h4);
        chk("ch2_intr_channel", bus.intr_channel, 32'd3);
        cyc();
        enq_set(2, 32'hDEAD_BEEF);
        cyc();
        enq_clr();
        for (int i = 1; i <= 8; i++) begin
            deq_one(2, 32'hA5A5_0000 + 32'(i));
        end
        at_neg();
        chk("ch2_drained_not_empty", 32'(bus.not_empty), 32'h0);
        chk("ch2_drained_deq_rdy", 32'(bus.deq_rdy), 32'h0);
        chk("ch2_drained_first", bus.first, 32'h0);

        // Channel 1: full, then simultaneous enq/deq across pointer wrap
        cyc();
        for (int i = 0; i < 8; i++) begin
            enq_set(1, 32'h100 + 32'(i));
            cyc();
        end
        enq_clr();
        for (int k = 0; k < 4; k++) begin
            enq_set(1, 32'h200 + 32'(k));
            bus.deq_sel = CW'(1);
            bus.deq_en  = 1'b1;
            exp_q.push_back(32'h100 + 32'(k));
            cyc();
        end
        enq_clr();
        bus.deq_en = 1'b0;
        at_neg();
        chk("ch1_still_full", 32'(bus.enq_rdy), 32'hD);
        cyc();
        for (int i = 4; i < 8; i++) begin
            deq_one(1, 32'h100 + 32'(i));
        end
        for (int k = 0; k < 4; k++) begin
            deq_one(1, 32'h200 + 32'(k));
        end
        at_neg();
        chk("ch1_drained", 32'(bus.not_empty), 32'h0);

        // Interrupt encoding and masking
        cyc();
        cyc();
        enq_set(3, 32'h11);
        cyc();
        enq_clr();
        enq_set(1, 32'h22);
        at_neg();
        chk("intr_latency_status", 32'(bus.intr_status), 32'h0);
        chk("intr_latency_ne", 32'(bus.not_empty), 32'h8);
        cyc();
        enq_clr();
        at_neg();
        chk("intr_ch3_status", 32'(bus.intr_status), 32'h1);
        chk("intr_ch3_channel", bus.intr_channel, 32'd4);
        cyc();
        at_neg();
        chk("intr_ch1_channel", bus.intr_channel, 32'd2);
        cyc();
        mask_wr(4'b1101);
        cyc();
        at_neg();
        chk("intr_mask1101_channel", bus.intr_channel, 32'd4);
        cyc();
        mask_wr(4'b0000);
        cyc();
        at_neg();
        chk("intr_mask0_status", 32'(bus.intr_status), 32'h0);
        chk("intr_mask0_channel", bus.intr_channel, 32'h0);
        chk("intr_mask0_data_kept", 32'(bus.not_empty), 32'hA);
        cyc();
        deq_one(3, 32'h11);
        deq_one(1, 32'h22);
        mask_wr(4'b1111);

        // Reset mid-burst discards data and restores the mask
        mask_wr(4'b0000);
        for (int i = 1; i <= 3; i++) begin
            enq_set(0, 32'(i));
            cyc();
        end
        enq_clr();
        bus.deq_sel = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        at_neg();
        chk("midrst_not_empty", 32'(bus.not_empty), 32'h0);
        chk("midrst_intr_status", 32'(bus.intr_status), 32'h0);
        chk("midrst_enq_rdy", 32'(bus.enq_rdy), 32'hF);
        chk("midrst_deq_rdy", 32'(bus.deq_rdy), 32'h0);
        chk("midrst_first", bus.first, 32'h0);
        cyc();
        enq_set(2, 32'h77);
        cyc();
        enq_clr();
        cyc();
        at_neg();
        chk("midrst_mask_ones_status", 32'(bus.intr_status), 32'h1);
        chk("midrst_mask_ones_channel", bus.intr_channel, 32'd3);
        cyc();
        deq_one(2, 32'h77);

        // Arbitration between ch0 and ch2 after popping ch0
        cyc();
        enq_set(0, 32'h1);
        enq_set(2, 32'h3);
        cyc();
        enq_clr();
        enq_set(0, 32'h2);
        cyc();
        enq_clr();
        cyc();
        at_neg();
        chk("arb_before_channel", bus.intr_channel, 32'd1);
        cyc();
        deq_one(0, 32'h1);
        cyc();
        at_neg();
`ifdef PORTAL_IND_MUX_ROUND_ROBIN_EN
        chk("arb_after_channel", bus.intr_channel, 32'd3);
`else
        chk("arb_after_channel", bus.intr_channel, 32'd1);
`endif
        chk("arb_ch0_still_queued", 32'(bus.not_empty), 32'h5);
        cyc();
        deq_one(0, 32'h2);
        deq_one(2, 32'h3);

        cyc();
        at_neg();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        chk("final_not_empty", 32'(bus.not_empty), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
